// File: rtl/classify_pkg.sv
// Shared types and classifier rules for the number sweep sequencer.
package classify_pkg;

    localparam int VAL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_div3(input logic [VAL_W-1:0] v);
        logic r;
        r = 1'b0;
        case (v)
            4'd3, 4'd6, 4'd9, 4'd12, 4'd15: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_even(input logic [VAL_W-1:0] v);
        return (v != '0) && !v[0];
    endfunction

endpackage

// File: rtl/classify_sweep_ctrl_if.sv
// Sweep request and result bundle between front end and sequencer.
interface classify_sweep_ctrl_if #(
    parameter int CNT_W = 5
) ();
    import classify_pkg::*;

    logic             start;
    logic [VAL_W-1:0] lo;
    logic [VAL_W-1:0] hi;
    logic             busy;
    logic             done;
    logic             err;
    logic [VAL_W-1:0] cur;
    logic             led0;
    logic             led1;
    logic [CNT_W-1:0] div3_cnt;
    logic [CNT_W-1:0] even_cnt;

    modport master (
        output start, lo, hi,
        input  busy, done, err, cur, led0, led1, div3_cnt, even_cnt
    );

    modport slave (
        input  start, lo, hi,
        output busy, done, err, cur, led0, led1, div3_cnt, even_cnt
    );

endinterface

// File: rtl/num_classifier.sv
// Standalone 4-bit classifier: divisible-by-3 and even flags.
module num_classifier
    import classify_pkg::*;
(
    input  logic [VAL_W-1:0] val,
    output logic             div3,
    output logic             even
);

    assign div3 = is_div3(val);
    assign even = is_even(val);

endmodule

// File: rtl/classify_sweep_ctrl.sv
// Steps the classifier across [lo, hi], holding each value and tallying hits.
module classify_sweep_ctrl
    import classify_pkg::*;
#(
    parameter int STEP_CYCLES = 4,
    parameter int CNT_W       = 5
) (
    input logic                 clk,
    input logic                 rst,
    classify_sweep_ctrl_if.slave bus
);

    localparam int HW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(STEP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [VAL_W-1:0] cur_q, cur_d;
    logic [VAL_W-1:0] hi_q, hi_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] div3_cnt_q, div3_cnt_d;
    logic [CNT_W-1:0] even_cnt_q, even_cnt_d;
    logic             err_q, err_d;
    logic             c_div3, c_even;

    num_classifier u_cls (
        .val  (cur_q),
        .div3 (c_div3),
        .even (c_even)
    );

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        hi_d       = hi_q;
        hold_cnt_d = hold_cnt_q;
        div3_cnt_d = div3_cnt_q;
        even_cnt_d = even_cnt_q;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.lo <= bus.hi) begin
                        hi_d       = bus.hi;
                        cur_d      = bus.lo;
                        hold_cnt_d = '0;
                        div3_cnt_d = '0;
                        even_cnt_d = '0;
                        state_d    = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    div3_cnt_d = div3_cnt_q + CNT_W'(c_div3);
                    even_cnt_d = even_cnt_q + CNT_W'(c_even);
                    // cur stops at hi so hi=15 never wraps
                    if (cur_q == hi_q) state_d = DONE;
                    else               cur_d   = cur_q + 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            hi_q       <= '0;
            hold_cnt_q <= '0;
            div3_cnt_q <= '0;
            even_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            hi_q       <= hi_d;
            hold_cnt_q <= hold_cnt_d;
            div3_cnt_q <= div3_cnt_d;
            even_cnt_q <= even_cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.err      = err_q;
    assign bus.cur      = cur_q;
    assign bus.led0     = bus.busy & c_div3;
    assign bus.led1     = bus.busy & c_even;
    assign bus.div3_cnt = div3_cnt_q;
    assign bus.even_cnt = even_cnt_q;

endmodule
